// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Integer division truncates, so the line rate can be up to one clock per bit fast.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with show-ahead read data and registered full/empty/level flags.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [7:0]            din,
  input  logic                  rd,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [DEPTH_LOG2:0] wr_ptr_nxt;
  logic [DEPTH_LOG2:0] rd_ptr_nxt;
  logic                push;
  logic                pop;

  // Writes into a full FIFO are dropped even when a pop happens in the same cycle.
  assign push = wr && !full;
  assign pop  = rd && !empty;

  assign wr_ptr_nxt = wr_ptr + {{DEPTH_LOG2{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{DEPTH_LOG2{1'b0}}, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      // The extra pointer MSB separates "wrapped once" (full) from "caught up" (empty).
      full   <= (wr_ptr_nxt[DEPTH_LOG2] != rd_ptr_nxt[DEPTH_LOG2]) &&
                (wr_ptr_nxt[DEPTH_LOG2-1:0] == rd_ptr_nxt[DEPTH_LOG2-1:0]);
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      level  <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end
  end

  // Head of queue is always presented so the consumer can load it on the popping edge.
  assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO; return path for the control receiver.
//   state | meaning
//   IDLE  | line high, pop and load the next byte when the FIFO is non-empty
//   START | line low for one bit time
//   DATA  | shift out DATA_BITS bits, LSB first
//   STOP  | line high for STOP_BITS bit times
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data,
  input  logic                  wr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy,
  output logic                  tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 baud_tc;
  logic                 fifo_rd;
  logic [7:0]           fifo_dout;

  assign baud_tc = (baud_cnt == BAUD_TC);
  assign fifo_rd = (state == IDLE) && !empty;

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .din   (data),
    .rd    (fifo_rd),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr && full) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (!empty) begin
            shift    <= fifo_dout;
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              // tx takes the next bit directly so it stays registered without a cycle of lag.
              shift   <= shift >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: default-rate instance for exact frame timing, fast instance for FIFO behaviour.
module tb_uart_tx_fifo;

  localparam int F_CPB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] d_data = 8'h00;
  logic       d_wr = 1'b0;
  logic       d_full, d_empty, d_ovf, d_busy, d_tx;
  logic [4:0] d_level;

  logic [7:0] f_data = 8'h00;
  logic       f_wr = 1'b0;
  logic       f_full, f_empty, f_ovf, f_busy, f_tx;
  logic [4:0] f_level;

  uart_tx_fifo u_dut_def (
    .clk(clk), .rst(rst), .data(d_data), .wr(d_wr), .full(d_full), .empty(d_empty),
    .level(d_level), .overflow(d_ovf), .busy(d_busy), .tx(d_tx)
  );

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DEPTH_LOG2(4)) u_dut_fast (
    .clk(clk), .rst(rst), .data(f_data), .wr(f_wr), .full(f_full), .empty(f_empty),
    .level(f_level), .overflow(f_ovf), .busy(f_busy), .tx(f_tx)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         starts[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame decoder and scoreboard for the fast instance.
  logic [7:0] mon_b;
  bit         mon_abort;
  logic [7:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && f_tx === 1'b0) begin
        starts.push_back(cyc);
        mon_abort = 1'b0;
        mon_b = 8'h00;
        for (int c = 0; c < 10 * F_CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) mon_abort = 1'b1;
          if (!mon_abort) begin
            if (c == F_CPB / 2) chk("mon_start_bit", {31'd0, f_tx}, 32'd0);
            if (c >= F_CPB + F_CPB / 2 && c < 9 * F_CPB && (c - F_CPB - F_CPB / 2) % F_CPB == 0)
              mon_b[(c - F_CPB - F_CPB / 2) / F_CPB] = f_tx;
            if (c == 9 * F_CPB + F_CPB / 2) chk("mon_stop_bit", {31'd0, f_tx}, 32'd1);
          end
        end
        if (!mon_abort) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected_frame: got 0x%0h expected no frame", mon_b);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("mon_rx_byte", {24'd0, mon_b}, {24'd0, mon_exp});
          end
        end
      end
    end
  end

  bit         track = 1'b0;
  bit         saw_full = 1'b0;
  logic [4:0] peak = '0;
  always @(negedge clk) begin
    if (track) begin
      if (f_level > peak) peak = f_level;
      if (f_full) saw_full = 1'b1;
    end
  end

  task automatic f_write(input logic [7:0] v, input bit accept);
    f_data = v;
    f_wr = 1'b1;
    if (accept) exp_q.push_back(v);
    @(posedge clk);
    #1;
    f_wr = 1'b0;
  endtask

  task automatic wait_f_idle(input int max_cyc, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(f_empty && !f_busy) && n < max_cyc);
    repeat (3) @(negedge clk);
    chk({name, "_timeout"}, {31'd0, n < max_cyc}, 32'd1);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  logic [7:0] a5 = 8'hA5;
  logic       exp_tx;
  int         tx_err, busy_cnt, n0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, f_tx}, 32'd1);
    chk("rst_busy", {31'd0, f_busy}, 32'd0);
    chk("rst_full", {31'd0, f_full}, 32'd0);
    chk("rst_empty", {31'd0, f_empty}, 32'd1);
    chk("rst_level", {27'd0, f_level}, 32'd0);
    chk("rst_ovf", {31'd0, f_ovf}, 32'd0);
    chk("rst_def_tx", {31'd0, d_tx}, 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: single 0xA5 on the 234-clock instance, exact waveform
    d_data = 8'hA5;
    d_wr = 1'b1;
    @(posedge clk);
    #1;
    d_wr = 1'b0;
    @(negedge clk);
    chk("t1_level_after_wr", {27'd0, d_level}, 32'd1);
    chk("t1_tx_before_start", {31'd0, d_tx}, 32'd1);
    tx_err = 0;
    busy_cnt = 0;
    for (int k = 0; k < 2340; k++) begin
      @(negedge clk);
      if (k == 0) chk("t1_level_after_pop", {27'd0, d_level}, 32'd0);
      if (k < 234) exp_tx = 1'b0;
      else if (k < 2106) exp_tx = a5[(k - 234) / 234];
      else exp_tx = 1'b1;
      if (d_tx !== exp_tx) tx_err++;
      if (d_busy === 1'b1) busy_cnt++;
    end
    chk("t1_tx_waveform_errs", tx_err, 32'd0);
    chk("t1_busy_cycles", busy_cnt, 32'd2340);
    @(negedge clk);
    chk("t1_busy_end", {31'd0, d_busy}, 32'd0);
    chk("t1_tx_end", {31'd0, d_tx}, 32'd1);

    // 2: burst of 16 on the fast instance
    starts.delete();
    peak = '0;
    saw_full = 1'b0;
    track = 1'b1;
    for (int i = 0; i < 16; i++) f_write(8'(i), 1'b1);
    wait_f_idle(3000, "t2");
    track = 1'b0;
    chk("t2_peak_level", {27'd0, peak}, 32'd15);
    chk("t2_full_seen", {31'd0, saw_full}, 32'd0);
    chk("t2_frames", starts.size(), 32'd16);
    tx_err = 0;
    for (int i = 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != 10 * F_CPB + 1) tx_err++;
    chk("t2_gap_errs", tx_err, 32'd0);

    // 3: overflow while the transmitter is busy
    f_write(8'hEE, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      f_write(8'(8'h10 + i), i < 16);
      if (i == 15) begin
        chk("t3_full", {31'd0, f_full}, 32'd1);
        chk("t3_level16", {27'd0, f_level}, 32'd16);
        chk("t3_ovf_before", {31'd0, f_ovf}, 32'd0);
      end
    end
    chk("t3_ovf_set", {31'd0, f_ovf}, 32'd1);
    chk("t3_level_held", {27'd0, f_level}, 32'd16);
    wait_f_idle(3000, "t3");
    chk("t3_ovf_sticky", {31'd0, f_ovf}, 32'd1);

    // 4: push and pop on the same edge at level 3
    f_write(8'h41, 1'b1);
    f_write(8'h42, 1'b1);
    f_write(8'h43, 1'b1);
    f_write(8'h44, 1'b1);
    repeat (98) @(posedge clk);
    #1;
    chk("t4_level_before", {27'd0, f_level}, 32'd3);
    chk("t4_idle_before", {31'd0, f_busy}, 32'd0);
    f_write(8'h45, 1'b1);
    chk("t4_level_after", {27'd0, f_level}, 32'd3);
    chk("t4_busy_after", {31'd0, f_busy}, 32'd1);
    wait_f_idle(2000, "t4");

    // 5: reset during data bit 4 of 0x3C, with a second byte queued
    f_write(8'h3C, 1'b0);
    f_write(8'h77, 1'b0);
    repeat (54) @(posedge clk);
    #1;
    chk("t5_busy_pre", {31'd0, f_busy}, 32'd1);
    chk("t5_bit4", {31'd0, f_tx}, 32'd1);
    chk("t5_level_pre", {27'd0, f_level}, 32'd1);
    rst = 1'b1;
    #2;
    chk("t5_tx_async", {31'd0, f_tx}, 32'd1);
    chk("t5_busy_async", {31'd0, f_busy}, 32'd0);
    chk("t5_level_async", {27'd0, f_level}, 32'd0);
    chk("t5_ovf_cleared", {31'd0, f_ovf}, 32'd0);
    chk("t5_empty_async", {31'd0, f_empty}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (120) @(negedge clk);
    n0 = starts.size();
    busy_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (f_busy !== 1'b0) busy_cnt++;
    end
    chk("t5_no_restart_busy", busy_cnt, 32'd0);
    chk("t5_no_restart_frames", starts.size(), n0);

    // 6: 0xFF at 10 clocks per bit: 10 low then 90 high
    f_write(8'hFF, 1'b1);
    @(negedge clk);
    chk("t6_tx_pre", {31'd0, f_tx}, 32'd1);
    tx_err = 0;
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (f_tx !== (k >= 10)) tx_err++;
      if (f_busy === 1'b1) busy_cnt++;
    end
    chk("t6_tx_waveform_errs", tx_err, 32'd0);
    chk("t6_busy_cycles", busy_cnt, 32'd100);
    wait_f_idle(300, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
